sprite_blitter: RTL and testbench
=================================

# sprite_blitter

Parametrised sprite drawing unit for the VGA path: on a `plot` request it scans a `SPR_W`×`SPR_H` sprite frame out of an external synchronous ROM and emits one framebuffer pixel write per clock to the VGA adapter. It adds four things to the fixed 16×16 poro drawer:
- selectable animation frames;
- screen-edge clipping;
- single-cycle-per-pixel pipelined streaming;
- optional colour-key transparency.

One instance sits between each game-object controller and the shared VGA write mux.

## Interface
- `X_W`, 9, x coordinate width
- `Y_W`, 8, y coordinate width
- `COLOUR_W`, 3, pixel colour width
- `SPR_W`, 16, sprite width in pixels (≥1)
- `SPR_H`, 16, sprite height in pixels (≥1)
- `FRAMES`, 4, frames stored back-to-back in ROM (≥1)
- `SCREEN_W`, 320, visible width
- `SCREEN_H`, 240, visible height
- `TRANSP_KEY`, 0, transparent colour (used only with the macro)

Ports:
- `clk`  in  1  single clock, all logic on its rising edge
- `resetn`  in  1  synchronous, active-low reset
- `plot`  in  1  start request, sampled only in IDLE
- `x_in`  in  X_W  sprite top-left x
- `y_in`  in  Y_W  sprite top-left y
- `frame_sel`  in  FS_W=max(1,clog2(FRAMES))  frame index
- `rom_addr`  out  RA_W=clog2(FRAMES·SPR_W·SPR_H)  ROM read address
- `rom_data`  in  COLOUR_W  ROM data, valid one cycle after `rom_addr`
- `x_out`  out  X_W  write x
- `y_out`  out  Y_W  write y
- `colour_out`  out  COLOUR_W  write colour
- `writeEn`  out  1  framebuffer write strobe
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle completion pulse

## Operation
- States: IDLE → DRAW → FLUSH → DONE → IDLE.
- IDLE, `plot`=1:
  - latch `x_in`, `y_in` and `frame_sel`;
  - a `frame_sel` ≥ FRAMES is latched as FRAMES−1;
  - clear the pixel counter (px, py) to (0,0);
  - go to DRAW.
- DRAW:
  - `rom_addr` = frame·SPR_W·SPR_H + py·SPR_W + px, combinational from latched frame and counter;
  - px increments each cycle; at SPR_W−1 it wraps to 0 and py increments;
  - on the cycle issuing (SPR_W−1, SPR_H−1), go to FLUSH.
- FLUSH: exactly 2 cycles to drain the pipeline, then DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Pipeline:
  - stage 1 registers the target coordinates sx = x0+px, sy = y0+py and a visibility bit;
  - the output stage registers `x_out`, `y_out` and `colour_out`=`rom_data`;
  - it asserts `writeEn` = stage-1 valid ∧ visible.
- Arithmetic: sums are computed in X_W+1 / Y_W+1 bits, so they never wrap. visible = (sx < SCREEN_W) ∧ (sy < SCREEN_H).
- Clipped pixels:
  - still consume their cycle, so latency is constant;
  - `writeEn` stays low for them.
- `x_out`, `y_out` and `colour_out` are meaningful only while `writeEn`=1.
- `plot` while `busy` is ignored, not queued.
- Reset mid-operation: next state IDLE and the pipeline valids cleared. No further writes, no `done`.

## Timing
- Reset values:
  - `x_out`, `y_out`, `colour_out` = 0;
  - `writeEn`, `done`, `busy` = 0;
  - counter = 0, so `rom_addr` = 0.
- Cycle 0 is the IDLE cycle with `plot`=1. Let N = SPR_W·SPR_H.
- Pixel i (scan order):
  - its address is driven in cycle 1+i;
  - its write (if visible) is in cycle 3+i.
- DRAW occupies cycles 1..N and FLUSH occupies N+1..N+2.
- The last possible write is in cycle N+2.
- `done` is high in cycle N+3, with `writeEn`=0.
- IDLE resumes at N+4, where a new `plot` is accepted.
- `busy` is high in cycles 1..N+3.
- Throughput: one pixel per clock.

## Configuration
- `SPRITE_TRANSPARENCY_EN` defined:
  - the visibility bit additionally requires `rom_data` ≠ TRANSP_KEY, evaluated in the output stage;
  - key-coloured pixels produce no write.
- Not defined: every in-bounds pixel is written; TRANSP_KEY is unused.
- Cycle timing is identical in both builds.

## Structure
- Package `sprite_pkg` holds:
  - the state enum (IDLE, DRAW, FLUSH, DONE);
  - default screen constants SCREEN_W/SCREEN_H;
  - colour constants, including the default key.
- Sub-module `sprite_scan_counter` holds:
  - the px/py counter with wrap and last-pixel flag;
  - the base-address multiply-add.
- The top level owns the FSM, the coordinate/visibility pipeline and the output registers.

## Test plan
- Defaults, `plot` at (10,20), frame 0:
  - 256 writes in cycles 3..258;
  - first write (10,20), last (25,35);
  - `rom_addr` runs 0..255;
  - `done` pulse in cycle 259.
- Clipping, `plot` at (312,236):
  - exactly 8×4 = 32 writes;
  - no write with x ≥ 320 or y ≥ 240;
  - `done` still in cycle 259.
- `frame_sel`:
  - `frame_sel`=2 → `rom_addr` starts at 512, ends at 767;
  - `frame_sel`=7 (clamped to 3) → starts at 768.
- `SPRITE_TRANSPARENCY_EN`, ROM frame 0 with 100 key-valued pixels → 156 writes, none carrying colour 0. Without the macro → 256 writes.
- `plot` pulsed again in cycle 50 → ignored, single `done`. Then `resetn`=0 in cycle 100 → `writeEn`, `busy` and `done` all 0 from cycle 101, no `done`.
- SPR_W=8, SPR_H=4, FRAMES=1 at (0,0):
  - 32 writes covering x 0..7, y 0..3;
  - `done` in cycle 35.

Source files
------------

// File: rtl/sprite_pkg.sv
// sprite_pkg: shared types and constants for the sprite blitter.
// Holds the FSM state enum, default screen size, colour constants and
// small elaboration-time helpers used for port widths and frame clamping.
package sprite_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAW  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DEFAULT_SCREEN_W   = 320;
  localparam int DEFAULT_SCREEN_H   = 240;

  localparam int COLOUR_BLACK       = 0;
  localparam int DEFAULT_TRANSP_KEY = COLOUR_BLACK;

  // Bit width needed to index v items, never less than one bit.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

  // Out-of-range frame requests fall back to the last stored frame.
  function automatic int clamp_frame(input int sel, input int frames);
    return (sel >= frames) ? (frames - 1) : sel;
  endfunction

endpackage

// File: rtl/sprite_scan_counter.sv
// sprite_scan_counter: raster pixel counter for one sprite frame.
// Walks (px, py) across SPR_W x SPR_H in scan order, flags the last pixel,
// and forms the ROM address frame*SPR_W*SPR_H + py*SPR_W + px.
module sprite_scan_counter
  import sprite_pkg::*;
#(
  parameter int SPR_W = 16,
  parameter int SPR_H = 16,
  parameter int FS_W  = 2,
  parameter int RA_W  = 10,
  localparam int PX_W = clog2_min1(SPR_W),
  localparam int PY_W = clog2_min1(SPR_H)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            clear,
  input  logic            step,
  input  logic [FS_W-1:0] frame,
  output logic [PX_W-1:0] px,
  output logic [PY_W-1:0] py,
  output logic            last,
  output logic [RA_W-1:0] addr
);

  localparam int N_PIX = SPR_W * SPR_H;

  logic [PX_W-1:0] px_r;
  logic [PY_W-1:0] py_r;
  logic            px_end_s;
  logic            py_end_s;

  assign px_end_s = (px_r == PX_W'(SPR_W - 1));
  assign py_end_s = (py_r == PY_W'(SPR_H - 1));
  assign last     = px_end_s & py_end_s;
  assign px       = px_r;
  assign py       = py_r;

  // Counter: restart on a new request, advance in raster order once per draw cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      px_r <= {PX_W{1'b0}};
      py_r <= {PY_W{1'b0}};
    end else if (clear) begin
      px_r <= {PX_W{1'b0}};
      py_r <= {PY_W{1'b0}};
    end else if (step) begin
      if (px_end_s) begin
        px_r <= {PX_W{1'b0}};
        py_r <= py_end_s ? {PY_W{1'b0}} : (py_r + PY_W'(1));
      end else begin
        px_r <= px_r + PX_W'(1);
      end
    end else begin
      px_r <= px_r;
      py_r <= py_r;
    end
  end

  // Address: frame base plus raster offset, combinational so ROM sees it this cycle.
  always_comb begin
    addr = (RA_W'(frame) * RA_W'(N_PIX)) + (RA_W'(py_r) * RA_W'(SPR_W)) + RA_W'(px_r);
  end

endmodule

// File: rtl/sprite_blitter.sv
// sprite_blitter: streams one sprite frame from a synchronous ROM into
// framebuffer writes, one pixel per clock, clipping at the screen edge.
// Optional macro SPRITE_TRANSPARENCY_EN suppresses writes of TRANSP_KEY pixels.
module sprite_blitter
  import sprite_pkg::*;
#(
  parameter int X_W        = 9,
  parameter int Y_W        = 8,
  parameter int COLOUR_W   = 3,
  parameter int SPR_W      = 16,
  parameter int SPR_H      = 16,
  parameter int FRAMES     = 4,
  parameter int SCREEN_W   = DEFAULT_SCREEN_W,
  parameter int SCREEN_H   = DEFAULT_SCREEN_H,
  parameter int TRANSP_KEY = DEFAULT_TRANSP_KEY,
  localparam int FS_W      = clog2_min1(FRAMES),
  localparam int RA_W      = clog2_min1(FRAMES * SPR_W * SPR_H)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                plot,
  input  logic [X_W-1:0]      x_in,
  input  logic [Y_W-1:0]      y_in,
  input  logic [FS_W-1:0]     frame_sel,
  output logic [RA_W-1:0]     rom_addr,
  input  logic [COLOUR_W-1:0] rom_data,
  output logic [X_W-1:0]      x_out,
  output logic [Y_W-1:0]      y_out,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                writeEn,
  output logic                busy,
  output logic                done
);

  localparam int PX_W = clog2_min1(SPR_W);
  localparam int PY_W = clog2_min1(SPR_H);

`ifdef SPRITE_TRANSPARENCY_EN
  localparam bit TRANSP_ON = 1'b1;
`else
  localparam bit TRANSP_ON = 1'b0;
`endif

  state_t              state_r;
  state_t              next_state_s;
  logic                flush_cnt_r;
  logic                start_s;
  logic                drawing_s;
  logic                busy_s;
  logic                done_s;

  logic [X_W-1:0]      x0_r;
  logic [Y_W-1:0]      y0_r;
  logic [FS_W-1:0]     frame_r;
  logic [FS_W-1:0]     frame_clamp_s;

  logic [PX_W-1:0]     px_s;
  logic [PY_W-1:0]     py_s;
  logic                last_s;

  logic [X_W:0]        sx_s;
  logic [Y_W:0]        sy_s;
  logic                vis_s;
  logic [X_W-1:0]      s1_x_r;
  logic [Y_W-1:0]      s1_y_r;
  logic                s1_valid_r;
  logic                s1_vis_r;
  logic                key_drop_s;

  logic [X_W-1:0]      x_out_r;
  logic [Y_W-1:0]      y_out_r;
  logic [COLOUR_W-1:0] colour_out_r;
  logic                we_r;

  sprite_scan_counter #(
    .SPR_W (SPR_W),
    .SPR_H (SPR_H),
    .FS_W  (FS_W),
    .RA_W  (RA_W)
  ) u_scan (
    .clk    (clk),
    .resetn (resetn),
    .clear  (start_s),
    .step   (drawing_s),
    .frame  (frame_r),
    .px     (px_s),
    .py     (py_s),
    .last   (last_s),
    .addr   (rom_addr)
  );

  // FSM state register plus the two-cycle flush timer.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      flush_cnt_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      flush_cnt_r <= (state_r == ST_FLUSH) ? ~flush_cnt_r : 1'b0;
    end
  end

  // FSM next-state: draw until the last pixel is issued, flush two cycles, pulse done.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE:  next_state_s = plot ? ST_DRAW : ST_IDLE;
      ST_DRAW:  next_state_s = last_s ? ST_FLUSH : ST_DRAW;
      ST_FLUSH: next_state_s = flush_cnt_r ? ST_DONE : ST_FLUSH;
      ST_DONE:  next_state_s = ST_IDLE;
      default:  next_state_s = ST_IDLE;
    endcase
  end

  // FSM outputs: request acceptance, draw enable, busy and done decode.
  always_comb begin
    start_s   = 1'b0;
    drawing_s = 1'b0;
    busy_s    = 1'b1;
    done_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy_s  = 1'b0;
        start_s = plot;
      end
      ST_DRAW:  drawing_s = 1'b1;
      ST_FLUSH: busy_s    = 1'b1;
      ST_DONE:  done_s    = 1'b1;
      default:  busy_s    = 1'b0;
    endcase
  end

  assign busy = busy_s;
  assign done = done_s;

  // Frame clamp: an out-of-range request draws the last stored frame.
  always_comb begin
    frame_clamp_s = FS_W'(clamp_frame(int'(frame_sel), FRAMES));
  end

  // Request latch: position and frame captured only when a plot is accepted.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      x0_r    <= {X_W{1'b0}};
      y0_r    <= {Y_W{1'b0}};
      frame_r <= {FS_W{1'b0}};
    end else if (start_s) begin
      x0_r    <= x_in;
      y0_r    <= y_in;
      frame_r <= frame_clamp_s;
    end else begin
      x0_r    <= x0_r;
      y0_r    <= y0_r;
      frame_r <= frame_r;
    end
  end

  // Target coordinates one bit wider than the inputs so edge sums never wrap.
  always_comb begin
    sx_s  = (X_W+1)'(x0_r) + (X_W+1)'(px_s);
    sy_s  = (Y_W+1)'(y0_r) + (Y_W+1)'(py_s);
    vis_s = (sx_s < (X_W+1)'(SCREEN_W)) && (sy_s < (Y_W+1)'(SCREEN_H));
  end

  // Key test on the ROM word arriving this cycle; constant false without the macro.
  always_comb begin
    key_drop_s = TRANSP_ON && (rom_data == COLOUR_W'(TRANSP_KEY));
  end

  // Stage 1: coordinates and visibility aligned with the ROM read latency.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_valid_r <= 1'b0;
      s1_vis_r   <= 1'b0;
      s1_x_r     <= {X_W{1'b0}};
      s1_y_r     <= {Y_W{1'b0}};
    end else begin
      s1_valid_r <= drawing_s;
      s1_vis_r   <= vis_s;
      s1_x_r     <= sx_s[X_W-1:0];
      s1_y_r     <= sy_s[Y_W-1:0];
    end
  end

  // Output stage: register the write; data fields only move on valid pixels.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      we_r         <= 1'b0;
      x_out_r      <= {X_W{1'b0}};
      y_out_r      <= {Y_W{1'b0}};
      colour_out_r <= {COLOUR_W{1'b0}};
    end else begin
      we_r <= s1_valid_r & s1_vis_r & ~key_drop_s;
      if (s1_valid_r) begin
        x_out_r      <= s1_x_r;
        y_out_r      <= s1_y_r;
        colour_out_r <= rom_data;
      end else begin
        x_out_r      <= x_out_r;
        y_out_r      <= y_out_r;
        colour_out_r <= colour_out_r;
      end
    end
  end

  assign writeEn    = we_r;
  assign x_out      = x_out_r;
  assign y_out      = y_out_r;
  assign colour_out = colour_out_r;

endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter: randomized self-checking bench for sprite_blitter
// (default parameters). The reference model predicts every output from the
// cycle offset k since the accepted plot, using plain scan-order arithmetic.
module tb_sprite_blitter;

  localparam int SW = 16;
  localparam int SH = 16;
  localparam int FR = 4;
  localparam int N  = SW * SH;
`ifdef SPRITE_TRANSPARENCY_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       plot = 1'b0;
  logic [8:0] x_in = 9'd0;
  logic [7:0] y_in = 8'd0;
  logic [1:0] frame_sel = 2'd0;
  logic [9:0] rom_addr;
  logic [2:0] rom_data;
  logic [8:0] x_out;
  logic [7:0] y_out;
  logic [2:0] colour_out;
  logic       writeEn;
  logic       busy;
  logic       done;

  logic [2:0] rom_mem [0:FR*N-1];

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int st = -1;
  int op_x, op_y, op_f;
  bit fresh = 1'b1;
  bit chk_en = 1'b0;
  int wr_cnt, done_cnt, first_k, last_k, fx, fy, lx, ly, done_k, a_first, a_last;

  sprite_blitter dut (
    .clk        (clk),
    .resetn     (resetn),
    .plot       (plot),
    .x_in       (x_in),
    .y_in       (y_in),
    .frame_sel  (frame_sel),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .x_out      (x_out),
    .y_out      (y_out),
    .colour_out (colour_out),
    .writeEn    (writeEn),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_data <= rom_mem[rom_addr];
    cyc      <= cyc + 1;
  end

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    int k, i, px, py, sx, sy, e_col;
    bit e_we;
    if (chk_en) begin
      k = (st >= 0) ? (cyc - st) : -1;
      check("busy", int'(busy), int'(k >= 1 && k <= N + 3));
      check("done", int'(done), int'(k == N + 3));
      e_we  = 1'b0;
      e_col = 0;
      sx = 0;
      sy = 0;
      if (k >= 3 && k <= N + 2) begin
        i     = k - 3;
        px    = i % SW;
        py    = i / SW;
        sx    = op_x + px;
        sy    = op_y + py;
        e_col = int'(rom_mem[op_f * N + i]);
        e_we  = (sx < 320) && (sy < 240) && !(TR && e_col == 0);
      end
      check("writeEn", int'(writeEn), int'(e_we));
      if (e_we) begin
        check("x_out", int'(x_out), sx);
        check("y_out", int'(y_out), sy);
        check("colour_out", int'(colour_out), e_col);
      end
      if (k >= 1 && k <= N) check("rom_addr", int'(rom_addr), op_f * N + k - 1);
      if (fresh) begin
        check("reset rom_addr", int'(rom_addr), 0);
        check("reset x_out", int'(x_out), 0);
        check("reset y_out", int'(y_out), 0);
        check("reset colour_out", int'(colour_out), 0);
      end
      if (k >= 0) begin
        if (writeEn) begin
          wr_cnt++;
          if (first_k < 0) begin
            first_k = k;
            fx = int'(x_out);
            fy = int'(y_out);
          end
          last_k = k;
          lx = int'(x_out);
          ly = int'(y_out);
        end
        if (done) begin
          done_cnt++;
          done_k = k;
        end
        if (k == 1) a_first = int'(rom_addr);
        if (k == N) a_last = int'(rom_addr);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive plot for one cycle; the model accepts it only if the blitter is idle.
  task automatic do_plot(input int x, input int y, input int f);
    plot      = 1'b1;
    x_in      = x[8:0];
    y_in      = y[7:0];
    frame_sel = f[1:0];
    if (st < 0 || (cyc - st) >= N + 4) begin
      st       = cyc;
      op_x     = int'(x_in);
      op_y     = int'(y_in);
      op_f     = (int'(frame_sel) >= FR) ? FR - 1 : int'(frame_sel);
      fresh    = 1'b0;
      wr_cnt   = 0;
      done_cnt = 0;
      first_k  = -1;
      last_k   = -1;
      done_k   = -1;
      a_first  = -1;
      a_last   = -1;
    end
    tick();
    plot = 1'b0;
  endtask

  task automatic run_op(input int x, input int y, input int f);
    do_plot(x, y, f);
    repeat (N + 3) tick();
  endtask

  task automatic run_rand_op;
    do_plot($urandom_range(0, 330), $urandom_range(0, 250), $urandom_range(0, 3));
    for (int c = 0; c < N + 3; c++) begin
      if ($urandom_range(0, 63) == 0)
        do_plot($urandom_range(0, 511), $urandom_range(0, 255), $urandom_range(0, 3));
      else
        tick();
    end
  endtask

  initial begin
    // Frame 0 holds exactly 100 key-coloured pixels, none at either end.
    for (int i = 0; i < N; i++)
      rom_mem[i] = (((i * 37 + 200) % 256) < 100) ? 3'd0 : 3'($urandom_range(1, 7));
    for (int i = N; i < FR * N; i++)
      rom_mem[i] = 3'($urandom_range(1, 7));

    resetn = 1'b0;
    repeat (2) tick();
    chk_en = 1'b1;
    tick();
    resetn = 1'b1;
    repeat (2) tick();

    // Main case at (10,20), frame 0.
    run_op(10, 20, 0);
    check("f0 writes", wr_cnt, TR ? 156 : 256);
    check("f0 first k", first_k, 3);
    check("f0 first x", fx, 10);
    check("f0 first y", fy, 20);
    check("f0 last k", last_k, 258);
    check("f0 last x", lx, 25);
    check("f0 last y", ly, 35);
    check("f0 done k", done_k, 259);
    check("f0 addr first", a_first, 0);
    check("f0 addr last", a_last, 255);

    // Clipping at the bottom-right corner.
    run_op(312, 236, 1);
    check("clip writes", wr_cnt, 32);
    check("clip first k", first_k, 3);
    check("clip last k", last_k, 58);
    check("clip last x", lx, 319);
    check("clip last y", ly, 239);
    check("clip done k", done_k, 259);

    // Frame selection.
    run_op(100, 50, 2);
    check("f2 writes", wr_cnt, 256);
    check("f2 addr first", a_first, 512);
    check("f2 addr last", a_last, 767);
    run_op(0, 0, 7);
    check("f7 addr first", a_first, 768);
    check("f7 addr last", a_last, 1023);

    // Maximum coordinates: sums must not wrap back on screen.
    run_op(511, 255, 3);
    check("nowrap writes", wr_cnt, 0);
    check("nowrap done k", done_k, 259);
    check("nowrap done count", done_cnt, 1);

    // Plot while busy is ignored, then reset mid-draw at k=100.
    do_plot(40, 40, 1);
    repeat (49) tick();
    do_plot(200, 100, 2);
    repeat (49) tick();
    resetn = 1'b0;
    @(negedge clk);
    #1;
    st    = -1;
    fresh = 1'b1;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    repeat (5) tick();
    check("abort writes", wr_cnt, 98);
    check("abort last k", last_k, 100);
    check("abort done count", done_cnt, 0);

    // Randomized operations, back to back, with stray plots during busy.
    for (int n = 0; n < 20; n++) begin
      run_rand_op();
      check("rand done count", done_cnt, 1);
      repeat ($urandom_range(0, 3)) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
